// File: rtl/cim_pkg.sv
// cim_pkg: shared constants, width helpers and pipeline tag type for the CIM MAC array
package cim_pkg;
    localparam int N_LANE_D  = 32;
    localparam int W_BITS_D  = 4;
    localparam int A_BITS_D  = 4;
    localparam int N_CH_D    = 4;
    localparam int MAX_ACC_D = 4;

    function automatic int clog2(input int v);
        int r = 0;
        for (int i = 0; i < 31; i++) r = ((1 << i) < v) ? i + 1 : r;
        return r;
    endfunction

    function automatic int out_width(input int n_lane, input int w_bits, input int a_bits, input int max_acc);
        return w_bits + a_bits + clog2(n_lane) + clog2(max_acc);
    endfunction

    // Per-beat control that travels alongside the data through S1/S2.
    typedef struct packed {
        logic valid;
        logic first;
        logic last;
        logic sgn;
        logic relu;
    } tag_t;
endpackage

// File: rtl/cim_dot_row.sv
// cim_dot_row: one weight row, S1 lane multipliers and S2 balanced adder tree
//   clk     rising-edge clock
//   valid   capture this cycle's products
//   sgn     operands are two's complement for this beat
//   weights N_LANE x W_BITS, lane 0 in MSBs
//   ifm     N_LANE x A_BITS, lane 0 in MSBs
//   sum     registered signed sum of the row, valid one cycle after the products
module cim_dot_row import cim_pkg::*; #(
    parameter int N_LANE = N_LANE_D,
    parameter int W_BITS = W_BITS_D,
    parameter int A_BITS = A_BITS_D,
    localparam int SW = W_BITS + A_BITS + clog2(N_LANE) + 1
) (
    input  logic                     clk,
    input  logic                     valid,
    input  logic                     sgn,
    input  logic [N_LANE*W_BITS-1:0] weights,
    input  logic [N_LANE*A_BITS-1:0] ifm,
    output logic [SW-1:0]            sum
);
    localparam int P  = W_BITS + A_BITS;
    localparam int LG = clog2(N_LANE);

    logic [N_LANE-1:0][P-1:0] prod_d, prod;
    logic                     sgn_q;

    // Operands are extended to the full product width, so the low P bits of
    // the product are exact in both signed and unsigned mode.
    for (genvar j = 0; j < N_LANE; j++) begin : ln
        logic [W_BITS-1:0] w;
        logic [A_BITS-1:0] a;
        logic [P-1:0]      we, ae;
        assign w  = weights[(N_LANE-1-j)*W_BITS +: W_BITS];
        assign a  = ifm[(N_LANE-1-j)*A_BITS +: A_BITS];
        assign we = {{A_BITS{sgn & w[W_BITS-1]}}, w};
        assign ae = {{W_BITS{sgn & a[A_BITS-1]}}, a};
        assign prod_d[j] = we * ae;
    end

    always_ff @(posedge clk) begin
        if (valid) begin
            prod  <= prod_d;
            sgn_q <= sgn;
        end
    end

    // The extra sign bit in SW lets unsigned sums stay positive under sign extension.
    for (genvar l = 0; l <= LG; l++) begin : lv
        logic [(N_LANE>>l)-1:0][SW-1:0] s;
        for (genvar j = 0; j < (N_LANE >> l); j++) begin : n
            if (l == 0) begin : leaf
                assign s[j] = {{(SW-P){sgn_q & prod[j][P-1]}}, prod[j]};
            end else begin : add
                assign s[j] = lv[l-1].s[2*j] + lv[l-1].s[2*j+1];
            end
        end
    end

    always_ff @(posedge clk) sum <= lv[LG].s[0];
endmodule

// File: rtl/cim_mac_array.sv
// cim_mac_array: N_CH parallel CIM dot-product rows with accumulation, ReLU and saturation
//   weight_valid/weight_ch/In_Weight  write one weight row (lane 0 in MSBs)
//   in_valid/In_IFM                   one IFM beat per cycle, no backpressure
//   cfg_signed/cfg_relu/cfg_acc_len   group config, captured on the first beat of a group
//   out_valid/Out_OFM                 one-cycle result pulse per group, channel 0 in MSBs
//   busy                              a group is in the accumulator awaiting its result
module cim_mac_array import cim_pkg::*; #(
    parameter int N_LANE  = N_LANE_D,
    parameter int W_BITS  = W_BITS_D,
    parameter int A_BITS  = A_BITS_D,
    parameter int N_CH    = N_CH_D,
    parameter int MAX_ACC = MAX_ACC_D,
    parameter int OUT_W   = out_width(N_LANE, W_BITS, A_BITS, MAX_ACC),
    localparam int CW = clog2(N_CH),
    localparam int LW = clog2(MAX_ACC) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     weight_valid,
    input  logic [CW-1:0]            weight_ch,
    input  logic [N_LANE*W_BITS-1:0] In_Weight,
    input  logic                     in_valid,
    input  logic [N_LANE*A_BITS-1:0] In_IFM,
    input  logic                     cfg_signed,
    input  logic                     cfg_relu,
    input  logic [LW-1:0]            cfg_acc_len,
    output logic                     out_valid,
    output logic [N_CH*OUT_W-1:0]    Out_OFM,
    output logic                     busy
);
    localparam int SW    = W_BITS + A_BITS + clog2(N_LANE) + 1;
    // Never narrower than a full group can grow, so a narrow OUT_W saturates instead of wrapping.
    localparam int ACC_W = (OUT_W + 1 > SW + clog2(MAX_ACC)) ? OUT_W + 1 : SW + clog2(MAX_ACC);
    localparam logic [LW-1:0] ONE  = LW'(1);
    localparam logic [LW-1:0] MAXL = LW'(MAX_ACC);
    localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((longint'(1) << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SMIN = ACC_W'(-(longint'(1) << (OUT_W - 1)));
    localparam logic signed [ACC_W-1:0] UMAX = ACC_W'((longint'(1) << OUT_W) - 1);

    logic [N_LANE*W_BITS-1:0]        wrow [N_CH];
    logic [LW-1:0]                   in_cnt, len_q, len_in, len_eff;
    logic                            sgn_q, relu_q, is_first, is_last, sgn_eff;
    tag_t                            t_in, t1, t2;
    logic                            done, done_sgn, done_relu;
    logic [N_CH-1:0][SW-1:0]         sums;
    logic [N_CH-1:0][ACC_W-1:0]      acc;
    logic [0:N_CH-1][OUT_W-1:0]      res;
    logic signed [ACC_W-1:0]         v;

    // Config for a group comes from the ports on its first beat, then from the latch.
    always_comb begin
        is_first = in_cnt == '0;
        len_in   = (cfg_acc_len == '0) ? ONE : ((cfg_acc_len > MAXL) ? MAXL : cfg_acc_len);
        len_eff  = is_first ? len_in : len_q;
        is_last  = in_cnt + ONE == len_eff;
        sgn_eff  = is_first ? cfg_signed : sgn_q;
        t_in     = '{valid: in_valid, first: is_first, last: is_last, sgn: sgn_eff,
                     relu: is_first ? cfg_relu : relu_q};
    end

    // An out-of-range weight_ch matches no row and is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++) wrow[c] <= '0;
        end else if (weight_valid) begin
            for (int c = 0; c < N_CH; c++) if (weight_ch == CW'(c)) wrow[c] <= In_Weight;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : row
        cim_dot_row #(.N_LANE(N_LANE), .W_BITS(W_BITS), .A_BITS(A_BITS)) u_row (
            .clk(clk), .valid(in_valid), .sgn(sgn_eff),
            .weights(wrow[c]), .ifm(In_IFM), .sum(sums[c])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_cnt    <= '0;
            len_q     <= ONE;
            sgn_q     <= 1'b0;
            relu_q    <= 1'b0;
            t1        <= '0;
            t2        <= '0;
            done      <= 1'b0;
            done_sgn  <= 1'b0;
            done_relu <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (in_valid) begin
                in_cnt <= is_last ? '0 : in_cnt + ONE;
                if (is_first) begin
                    len_q  <= len_in;
                    sgn_q  <= cfg_signed;
                    relu_q <= cfg_relu;
                end
            end
            t1        <= t_in;
            t2        <= t1;
            done      <= t2.valid & t2.last;
            done_sgn  <= t2.sgn;
            done_relu <= t2.relu;
            busy      <= t2.valid | (busy & ~done);
            out_valid <= done;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            Out_OFM <= '0;
        end else begin
            if (t2.valid)
                for (int c = 0; c < N_CH; c++)
                    acc[c] <= (t2.first ? '0 : acc[c]) + {{(ACC_W-SW){sums[c][SW-1]}}, sums[c]};
            if (done) Out_OFM <= res;
        end
    end

    // ReLU first, then clamp to the OUT_W range of the group's mode.
    always_comb begin
        res = '0;
        v   = '0;
        for (int c = 0; c < N_CH; c++) begin
            v = (done_relu & acc[c][ACC_W-1]) ? '0 : $signed(acc[c]);
            v = done_sgn ? ((v > SMAX) ? SMAX : ((v < SMIN) ? SMIN : v))
                         : (v[ACC_W-1] ? '0 : ((v > UMAX) ? UMAX : v));
            res[c] = v[OUT_W-1:0];
        end
    end
endmodule

// File: tb/tb_cim_mac_array.sv
// tb_cim_mac_array: directed self-checking bench for cim_mac_array (default and OUT_W=13 builds)
module tb_cim_mac_array;
    localparam int NL = 32;
    localparam int NC = 4;
    localparam int OW = 15;

    logic         clk = 1'b0, rst = 1'b1;
    logic         weight_valid = 1'b0, in_valid = 1'b0, cfg_signed = 1'b0, cfg_relu = 1'b0;
    logic [1:0]   weight_ch = '0;
    logic [127:0] In_Weight = '0, In_IFM = '0;
    logic [2:0]   cfg_acc_len = 3'd1;
    logic         out_valid, busy, out_valid13, busy13;
    logic [59:0]  Out_OFM;
    logic [51:0]  ofm13;
    int           n_cmp = 0, n_err = 0;
    int           nb, np, nw;

    always #5 clk = ~clk;

    cim_mac_array dut (
        .clk(clk), .rst(rst), .weight_valid(weight_valid), .weight_ch(weight_ch),
        .In_Weight(In_Weight), .in_valid(in_valid), .In_IFM(In_IFM),
        .cfg_signed(cfg_signed), .cfg_relu(cfg_relu), .cfg_acc_len(cfg_acc_len),
        .out_valid(out_valid), .Out_OFM(Out_OFM), .busy(busy)
    );

    cim_mac_array #(.OUT_W(13)) dut13 (
        .clk(clk), .rst(rst), .weight_valid(weight_valid), .weight_ch(weight_ch),
        .In_Weight(In_Weight), .in_valid(in_valid), .In_IFM(In_IFM),
        .cfg_signed(cfg_signed), .cfg_relu(cfg_relu), .cfg_acc_len(cfg_acc_len),
        .out_valid(out_valid13), .Out_OFM(ofm13), .busy(busy13)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic [14:0] ch(input int i);
        return Out_OFM[(NC-1-i)*OW +: OW];
    endfunction

    task automatic chk_all(input string tag, input logic [14:0] e0, input logic [14:0] e1,
                           input logic [14:0] e2, input logic [14:0] e3);
        chk($sformatf("%s.ch0", tag), 64'(ch(0)), 64'(e0));
        chk($sformatf("%s.ch1", tag), 64'(ch(1)), 64'(e1));
        chk($sformatf("%s.ch2", tag), 64'(ch(2)), 64'(e2));
        chk($sformatf("%s.ch3", tag), 64'(ch(3)), 64'(e3));
    endtask

    task automatic wr(input int c, input logic [3:0] w);
        weight_valid = 1'b1;
        weight_ch    = 2'(c);
        In_Weight    = {NL{w}};
        tick;
        weight_valid = 1'b0;
    endtask

    task automatic wr_all(input logic [3:0] w);
        for (int c = 0; c < NC; c++) wr(c, w);
    endtask

    task automatic beat(input logic [3:0] a);
        in_valid = 1'b1;
        In_IFM   = {NL{a}};
        tick;
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        tick;
        tick;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_ofm", 64'(Out_OFM), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;

        // 1: unsigned all-15, single beat, exact 3-cycle latency and 1-cycle pulse
        wr_all(4'hF);
        beat(4'hF);
        tick;
        tick;
        chk("t1_early", 64'(out_valid), 64'd0);
        chk("t1_busy", 64'(busy), 64'd1);
        tick;
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk_all("t1", 15'd7200, 15'd7200, 15'd7200, 15'd7200);
        tick;
        chk("t1_pulse", 64'(out_valid), 64'd0);
        chk("t1_hold", 64'(ch(0)), 64'd7200);
        chk("t1_idle", 64'(busy), 64'd0);

        // 2: signed -8 * 7, then with ReLU
        cfg_signed = 1'b1;
        wr_all(4'h8);
        beat(4'h7);
        tick; tick; tick;
        chk("t2_valid", 64'(out_valid), 64'd1);
        chk_all("t2", -15'sd1792, -15'sd1792, -15'sd1792, -15'sd1792);
        cfg_relu = 1'b1;
        beat(4'h7);
        tick; tick; tick;
        chk("t2r_valid", 64'(out_valid), 64'd1);
        chk_all("t2r", 15'd0, 15'd0, 15'd0, 15'd0);
        cfg_relu = 1'b0;

        // 3: unsigned 4-beat group
        cfg_signed  = 1'b0;
        cfg_acc_len = 3'd4;
        wr_all(4'hF);
        nb = 0;
        np = 0;
        in_valid = 1'b1;
        In_IFM   = {NL{4'hF}};
        for (int i = 0; i < 10; i++) begin
            if (i == 4) in_valid = 1'b0;
            tick;
            nb += int'(busy);
            np += int'(out_valid);
        end
        chk("t3_busy_cycles", 64'(nb), 64'd4);
        chk("t3_pulses", 64'(np), 64'd1);
        chk_all("t3", 15'd28800, 15'd28800, 15'd28800, 15'd28800);

        // 4: distinct rows, then a same-cycle rewrite of row 2
        cfg_acc_len = 3'd1;
        for (int c = 0; c < NC; c++) wr(c, 4'(c + 1));
        beat(4'h1);
        tick; tick; tick;
        chk("t4_valid", 64'(out_valid), 64'd1);
        chk_all("t4", 15'd32, 15'd64, 15'd96, 15'd128);
        weight_valid = 1'b1;
        weight_ch    = 2'd2;
        In_Weight    = '0;
        in_valid     = 1'b1;
        In_IFM       = {NL{4'h1}};
        tick;
        weight_valid = 1'b0;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        chk("t4_old_valid", 64'(out_valid), 64'd1);
        chk("t4_old_ch2", 64'(ch(2)), 64'd96);
        tick;
        chk("t4_b2b_valid", 64'(out_valid), 64'd1);
        chk("t4_new_ch2", 64'(ch(2)), 64'd0);
        chk("t4_new_ch3", 64'(ch(3)), 64'd128);

        // 5: signed 4-beat group with a stall and mid-group config change; 13-bit build saturates
        cfg_signed  = 1'b1;
        cfg_acc_len = 3'd4;
        wr_all(4'h8);
        beat(4'h8);
        cfg_signed  = 1'b0;
        cfg_acc_len = 3'd1;
        beat(4'h8);
        tick;
        tick;
        beat(4'h8);
        beat(4'h8);
        nw = 0;
        for (int i = 0; i < 8 && !out_valid; i++) begin
            tick;
            nw++;
        end
        chk("t5_valid", 64'(out_valid), 64'd1);
        chk("t5_latency", 64'(nw), 64'd3);
        chk_all("t5", 15'd8192, 15'd8192, 15'd8192, 15'd8192);
        chk("t5_w13_valid", 64'(out_valid13), 64'd1);
        chk("t5_w13_ch0", 64'(ofm13[51:39]), 64'd4095);
        chk("t5_w13_ch3", 64'(ofm13[12:0]), 64'd4095);

        // 6: reset mid-group aborts it and clears everything
        cfg_acc_len = 3'd4;
        wr_all(4'hF);
        beat(4'hF);
        beat(4'hF);
        rst = 1'b1;
        tick;
        tick;
        chk("t6_out_valid", 64'(out_valid), 64'd0);
        chk("t6_ofm", 64'(Out_OFM), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        np = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            np += int'(out_valid);
        end
        chk("t6_no_pulse", 64'(np), 64'd0);
        cfg_acc_len = 3'd1;
        beat(4'hF);
        tick; tick; tick;
        chk("t6_wzero_valid", 64'(out_valid), 64'd1);
        chk_all("t6_wzero", 15'd0, 15'd0, 15'd0, 15'd0);
        wr_all(4'hF);
        beat(4'hF);
        tick; tick; tick;
        chk("t6_fresh_valid", 64'(out_valid), 64'd1);
        chk_all("t6_fresh", 15'd7200, 15'd7200, 15'd7200, 15'd7200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
